bias_relu_stage: RTL and testbench

//  Post-accumulation stage for the conv layers: takes one beat of N_ADDER_TREE 18-bit

---
 rtl/bias_relu_stage.sv | 150 +++++++++++++++
 tb/tb_bias_relu_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_relu_stage.sv
// bias_relu_stage: post-accumulation stage for the conv layers.
// Adds the per-channel bias of the current channel group to each adder-tree lane,
// saturates to DW bits, optionally applies ReLU and registers the result.
// Two-stage stall-all pipeline: every register advances together when the output
// slot is free or being drained (en = !out_valid | out_ready).
// Build option: define BIAS_RELU_STAGE_RELU_EN to clamp negative results to zero
// (conv layers). Without it the saturated signed sum is passed through (classifier).
module bias_relu_stage #(
  parameter int N_ADDER_TREE = 16,
  parameter int N_GROUPS     = 2,
  parameter int DW           = 18,
  localparam int GW          = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int LW          = N_ADDER_TREE * DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_GROUPS*LW-1:0] bias_in,
  input  logic [LW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  output logic [LW-1:0]          out_data,
  output logic [GW-1:0]          out_group,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  // One guard bit above DW is enough to hold the sum of two DW-bit signed values.
  localparam int SW = DW + 1;

  logic          en;
  logic          in_xfer;
  logic [GW-1:0] grp;
  logic [GW-1:0] grp_next;
  logic [LW-1:0] bias_sel;
  logic [SW-1:0] sum_d  [N_ADDER_TREE];
  logic [SW-1:0] s1_sum [N_ADDER_TREE];
  logic          s1_valid;
  logic          s1_last;
  logic [GW-1:0] s1_grp;
  logic [LW-1:0] act_d;

  // Saturate a DW+1 bit sum to DW bits; overflow shows up as the two top bits disagreeing.
  function automatic logic [DW-1:0] sat_act(input logic [SW-1:0] s);
    logic [DW-1:0] r;
    if (s[SW-1] == s[SW-2]) begin
      r = s[DW-1:0];
    end else if (!s[SW-1]) begin
      r = {1'b0, {(DW-1){1'b1}}};
    end else begin
      r = {1'b1, {(DW-1){1'b0}}};
    end
`ifdef BIAS_RELU_STAGE_RELU_EN
    if (r[DW-1]) begin
      r = '0;
    end
`endif
    return r;
  endfunction

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign in_xfer  = in_valid && en;

  // Next group index: step per accepted beat, wrap at the last group, restart after in_last.
  always_comb begin
    grp_next = grp;
    if (in_xfer) begin
      if (in_last || (grp == GW'(N_GROUPS - 1))) begin
        grp_next = '0;
      end else begin
        grp_next = grp + 1'b1;
      end
    end
  end

  // Group counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp <= '0;
    end else begin
      grp <= grp_next;
    end
  end

  // Select the bias slice of the current group (constant slices, one per group).
  always_comb begin
    bias_sel = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (grp == GW'(g)) begin
        bias_sel = bias_in[g*LW +: LW];
      end
    end
  end

  // Sign-extended lane-wise bias add feeding stage 1.
  always_comb begin
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      sum_d[i] = '0;
    end
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      sum_d[i] = {in_data[DW*i+DW-1], in_data[DW*i +: DW]}
               + {bias_sel[DW*i+DW-1], bias_sel[DW*i +: DW]};
    end
  end

  // Stage 1: raw sums plus sideband; data loads on every enabled cycle, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ADDER_TREE; i++) begin
        s1_sum[i] <= '0;
      end
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_grp   <= '0;
    end else if (en) begin
      for (int i = 0; i < N_ADDER_TREE; i++) begin
        s1_sum[i] <= sum_d[i];
      end
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_grp   <= grp;
    end
  end

  // Saturation and activation of the stage-1 sums.
  always_comb begin
    act_d = '0;
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      act_d[DW*i +: DW] = sat_act(s1_sum[i]);
    end
  end

  // Stage 2: output registers, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_group <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_data  <= act_d;
      out_group <= s1_grp;
      out_valid <= s1_valid;
      out_last  <= s1_last;
    end
  end

endmodule

// File: tb/tb_bias_relu_stage.sv
// Testbench for bias_relu_stage: directed table, multi-cycle corner sequences and a
// randomized stream checked against a queue-based arithmetic reference model.
module tb_bias_relu_stage;
  localparam int N    = 16;
  localparam int G    = 2;
  localparam int DW   = 18;
  localparam int LW   = N * DW;
  localparam int BW   = G * LW;
  localparam int SMAX = 131071;
  localparam int SMIN = -131072;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] bias;
  logic [LW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [LW-1:0] out_data;
  logic [0:0]    out_group;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  bias_relu_stage #(.N_ADDER_TREE(N), .N_GROUPS(G), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bias_in(bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_group(out_group), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] data;
    int            grp;
    bit            last;
  } beat_t;

  typedef struct {
    int acc;
    int bias;
    int exp_relu;
    int exp_lin;
  } vec_t;

  beat_t         exp_q[$];
  logic [LW-1:0] obs_data[$];
  int            obs_grp[$];
  bit            obs_last[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            grp_m = 0;
  logic          smp_in_ready;
  logic          smp_out_valid;
  logic [LW-1:0] smp_out_data;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_lane(input int a, input int b);
    int s;
    s = a + b;
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
`ifdef BIAS_RELU_STAGE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic int lane(input logic [LW-1:0] v, input int i);
    logic [DW-1:0] x;
    x = v[DW*i +: DW];
    return int'($signed(x));
  endfunction

  function automatic logic [LW-1:0] ref_beat(input logic [LW-1:0] d, input int g);
    logic [LW-1:0] r;
    logic [DW-1:0] b;
    r = '0;
    for (int i = 0; i < N; i++) begin
      b = bias[DW*(g*N+i) +: DW];
      r[DW*i +: DW] = DW'(ref_lane(lane(d, i), int'($signed(b))));
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return DW'(SMAX - int'($urandom_range(0, 200)));
      1:       return DW'(SMIN + int'($urandom_range(0, 200)));
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [LW-1:0] rand_beat();
    logic [LW-1:0] d;
    for (int i = 0; i < N; i++) d[DW*i +: DW] = rand_lane();
    return d;
  endfunction

  // One clock cycle: drive at posedge+1, sample mid-cycle, score transfers, advance.
  task automatic drive_cycle(input bit v, input logic [LW-1:0] d, input bit l, input bit r,
                             output bit acc);
    beat_t e;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #3;
    smp_in_ready  = in_ready;
    smp_out_valid = out_valid;
    smp_out_data  = out_data;
    acc = v && in_ready;
    if (out_valid && r) begin
      obs_data.push_back(out_data);
      obs_grp.push_back(int'(out_group));
      obs_last.push_back(out_last);
      check("sb_pending", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_vec("sb_data", out_data, e.data);
        check("sb_group", longint'(out_group), e.grp);
        check("sb_last", longint'(out_last), longint'(e.last));
      end
    end
    if (acc) begin
      e.data = ref_beat(d, grp_m);
      e.grp  = grp_m;
      e.last = l;
      exp_q.push_back(e);
      grp_m = l ? 0 : (grp_m + 1) % G;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_grp.delete();
    obs_last.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    grp_m = 0;
    clear_obs();
  endtask

  task automatic wait_obs(input int n, input string name);
    bit a;
    for (int c = 0; c < 20 && obs_data.size() < n; c++) drive_cycle(0, '0, 0, 1, a);
    check(name, obs_data.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[12];
    bit            a;
    int            n0;
    int            ev;
    int            wrap_g[5];
    logic [LW-1:0] d;
    logic [LW-1:0] bp_beats[3];
    logic [LW-1:0] snap;
    logic [LW-1:0] prev_data;
    bit            prev_stall;
    bit            v;
    bit            r;

    tbl[0]  = '{5000,    -1840,   3160,   3160};
    tbl[1]  = '{-20000,  12020,   0,      -7980};
    tbl[2]  = '{131000,  1000,    131071, 131071};
    tbl[3]  = '{-131000, -1000,   0,      -131072};
    tbl[4]  = '{131071,  0,       131071, 131071};
    tbl[5]  = '{-131072, 0,       0,      -131072};
    tbl[6]  = '{131071,  131071,  131071, 131071};
    tbl[7]  = '{-131072, -131072, 0,      -131072};
    tbl[8]  = '{0,       0,       0,      0};
    tbl[9]  = '{1,       -2,      0,      -1};
    tbl[10] = '{65536,   65535,   131071, 131071};
    tbl[11] = '{-65536,  -65536,  0,      -131072};
    wrap_g  = '{0, 1, 0, 0, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0; bias = '0;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'(out_data != '0), 0);
    check("rst_out_group", out_group, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-beat vectors on lane 0 of group 0, with latency checks.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) bias[DW*i +: DW] = rand_lane();
      bias[DW-1:0] = DW'(tbl[k].bias);
      d = rand_beat();
      d[DW-1:0] = DW'(tbl[k].acc);
      n0 = obs_data.size();
      drive_cycle(1, d, 1, 1, a);
      check("tbl_accept", a, 1);
      drive_cycle(0, '0, 0, 1, a);
      check("tbl_latency_1", smp_out_valid, 0);
      drive_cycle(0, '0, 0, 1, a);
      check("tbl_latency_2", obs_data.size(), n0 + 1);
      if (obs_data.size() == n0 + 1) begin
`ifdef BIAS_RELU_STAGE_RELU_EN
        ev = tbl[k].exp_relu;
`else
        ev = tbl[k].exp_lin;
`endif
        check("tbl_lane0", lane(obs_data[n0], 0), ev);
        check("tbl_group", obs_grp[n0], 0);
        check("tbl_last", obs_last[n0], 1);
      end
    end

    // Group wrap and in_last restart: five back-to-back beats, last on the third.
    do_reset();
    bias = {rand_beat(), rand_beat()};
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1, rand_beat(), k == 2, 1, a);
      check("wrap_accept", a, 1);
    end
    wait_obs(5, "wrap_count");
    for (int k = 0; k < 5 && k < obs_grp.size(); k++) begin
      check("wrap_group", obs_grp[k], wrap_g[k]);
      check("wrap_last", obs_last[k], k == 2);
    end

    // Backpressure: consumer stalls, pipeline fills, output holds, nothing lost.
    do_reset();
    for (int k = 0; k < 3; k++) bp_beats[k] = rand_beat();
    drive_cycle(1, bp_beats[0], 0, 0, a);
    check("bp_accept0", a, 1);
    drive_cycle(1, bp_beats[1], 0, 0, a);
    check("bp_accept1", a, 1);
    snap = '0;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1, bp_beats[2], 0, 0, a);
      check("bp_in_ready", smp_in_ready, 0);
      check("bp_out_valid", smp_out_valid, 1);
      if (c == 0) snap = smp_out_data;
      else check_vec("bp_hold", smp_out_data, snap);
    end
    a = 1'b0;
    for (int c = 0; c < 10 && !a; c++) drive_cycle(1, bp_beats[2], 0, 1, a);
    check("bp_accept2", a, 1);
    wait_obs(3, "bp_count");
    for (int k = 0; k < 3 && k < obs_data.size(); k++) begin
      check_vec("bp_order", obs_data[k], ref_beat(bp_beats[k], k % G));
    end

    // Reset in mid-stream: outputs drop at once, counter restarts at group 0.
    do_reset();
    bias = {rand_beat(), rand_beat()};
    drive_cycle(1, rand_beat(), 0, 1, a);
    drive_cycle(1, rand_beat(), 0, 1, a);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", longint'(out_data != '0), 0);
    check("midrst_out_group", out_group, 0);
    exp_q.delete();
    grp_m = 0;
    clear_obs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = rand_beat();
    drive_cycle(1, d, 0, 1, a);
    check("midrst_accept", a, 1);
    wait_obs(1, "midrst_count");
    if (obs_data.size() == 1) begin
      check("midrst_group", obs_grp[0], 0);
      check_vec("midrst_data", obs_data[0], ref_beat(d, 0));
    end

    // Randomized traffic with bubbles, stalls and random in_last.
    do_reset();
    bias = {rand_beat(), rand_beat()};
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      drive_cycle(v, rand_beat(), $urandom_range(0, 7) == 0, r, a);
      check("rnd_in_ready", smp_in_ready, !smp_out_valid || r);
      if (prev_stall) check_vec("rnd_hold", smp_out_data, prev_data);
      prev_stall = smp_out_valid && !r;
      prev_data  = smp_out_data;
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) drive_cycle(0, '0, 0, 1, a);
    check("rnd_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
